// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Shares the register file's single write port between two writeback
// requesters: the ALU result path (source 0) and the memory-load path
// (source 1). Each requester hands over one write per handshake into its own
// one-entry holding buffer. Every cycle at most one buffered write is granted.
// The granted write appears on the registered Write_* outputs at the next
// rising edge.
//
// Optional feature (macro REGFILE_ARB_ROUND_ROBIN_EN):
//   undefined - fixed priority, MEM wins a contested grant, no pointer state.
//   defined   - a 1-bit pointer names the preferred source and flips to the
//               loser after every contested grant.
//   In both builds a same-address conflict always issues MEM first, so the
//   ALU value is the one left in the register.
//
// Ports:
//   Clock          in   system clock, rising edge
//   Reset          in   synchronous, active-high reset
//   alu_valid      in   ALU writeback request valid
//   alu_ready      out  ALU request accepted when valid && ready
//   alu_addr       in   ALU destination register  [ADDR_W]
//   alu_data       in   ALU result                [DATA_W]
//   mem_valid      in   load writeback request valid
//   mem_ready      out  load request accepted when valid && ready
//   mem_addr       in   load destination register [ADDR_W]
//   mem_data       in   load data                 [DATA_W]
//   Write_Enable   out  register-file write strobe (registered)
//   Write_Register out  register-file write index  (registered)
//   Write_Data     out  register-file write data   (registered)
//   grant_src      out  source of current write, 0 = ALU, 1 = MEM (registered)
//   busy           out  either holding buffer occupied
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 2
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [ADDR_W-1:0]          alu_addr,
  input  logic [DATA_W-1:0]          alu_data,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [ADDR_W-1:0]          mem_addr,
  input  logic [DATA_W-1:0]          mem_data,
  output logic                       Write_Enable,
  output logic [ADDR_W-1:0]          Write_Register,
  output logic [DATA_W-1:0]          Write_Data,
  output logic [$clog2(NUM_SRC)-1:0] grant_src,
  output logic                       busy
);

  localparam int SRC_W = $clog2(NUM_SRC);
  localparam logic [SRC_W-1:0] SRC_ALU = 1'b0;
  localparam logic [SRC_W-1:0] SRC_MEM = 1'b1;

  // Register 0 is hard-wired to zero, so writes to it carry no information.
  function automatic logic addr_is_live(input logic [ADDR_W-1:0] addr);
    return (addr != {ADDR_W{1'b0}});
  endfunction

  // Holding buffers
  logic              buf_alu_valid_r;
  logic [ADDR_W-1:0] buf_alu_addr_r;
  logic [DATA_W-1:0] buf_alu_data_r;
  logic              buf_mem_valid_r;
  logic [ADDR_W-1:0] buf_mem_addr_r;
  logic [DATA_W-1:0] buf_mem_data_r;

  // Arbitration results
  logic              both_s;
  logic              same_addr_s;
  logic              contested_s;
  logic              grant_alu_s;
  logic              grant_mem_s;
  logic              grant_any_s;
  logic              alu_accept_s;
  logic              mem_accept_s;
  logic [ADDR_W-1:0] issue_addr_s;
  logic [DATA_W-1:0] issue_data_s;
  logic [SRC_W-1:0]  issue_src_s;

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
  logic [SRC_W-1:0]  rr_ptr_r;
`endif

  assign both_s      = buf_alu_valid_r && buf_mem_valid_r;
  assign same_addr_s = both_s && (buf_alu_addr_r == buf_mem_addr_r);
  // Only a different-address conflict is a real choice; same-address is ordered.
  assign contested_s = both_s && !same_addr_s;
  assign grant_any_s = grant_alu_s || grant_mem_s;

  // Ready depends only on registered state: an empty buffer, or one that is
  // draining this cycle, can take a new entry at the coming edge.
  assign alu_ready    = !buf_alu_valid_r || grant_alu_s;
  assign mem_ready    = !buf_mem_valid_r || grant_mem_s;
  assign alu_accept_s = alu_valid && alu_ready;
  assign mem_accept_s = mem_valid && mem_ready;

  assign busy = buf_alu_valid_r || buf_mem_valid_r;

  // Grant selection over the occupied buffers
  always_comb begin
    grant_alu_s = 1'b0;
    grant_mem_s = 1'b0;
    if (both_s) begin
      if (same_addr_s) begin
        // MEM first so the younger ALU value lands last.
        grant_mem_s = 1'b1;
      end else begin
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
        if (rr_ptr_r == SRC_ALU) begin
          grant_alu_s = 1'b1;
        end else begin
          grant_mem_s = 1'b1;
        end
`else
        grant_mem_s = 1'b1;
`endif
      end
    end else if (buf_alu_valid_r) begin
      grant_alu_s = 1'b1;
    end else if (buf_mem_valid_r) begin
      grant_mem_s = 1'b1;
    end else begin
      grant_alu_s = 1'b0;
      grant_mem_s = 1'b0;
    end
  end

  // Write-port mux from the granted buffer
  always_comb begin
    issue_addr_s = buf_alu_addr_r;
    issue_data_s = buf_alu_data_r;
    issue_src_s  = SRC_ALU;
    if (grant_mem_s) begin
      issue_addr_s = buf_mem_addr_r;
      issue_data_s = buf_mem_data_r;
      issue_src_s  = SRC_MEM;
    end else begin
      issue_addr_s = buf_alu_addr_r;
      issue_data_s = buf_alu_data_r;
      issue_src_s  = SRC_ALU;
    end
  end

  // ALU holding buffer: a refill takes precedence over the drain on the same edge
  always_ff @(posedge Clock) begin
    if (Reset) begin
      buf_alu_valid_r <= 1'b0;
      buf_alu_addr_r  <= {ADDR_W{1'b0}};
      buf_alu_data_r  <= {DATA_W{1'b0}};
    end else if (alu_accept_s && addr_is_live(alu_addr)) begin
      buf_alu_valid_r <= 1'b1;
      buf_alu_addr_r  <= alu_addr;
      buf_alu_data_r  <= alu_data;
    end else if (grant_alu_s) begin
      buf_alu_valid_r <= 1'b0;
    end else begin
      buf_alu_valid_r <= buf_alu_valid_r;
    end
  end

  // MEM holding buffer: same policy as the ALU buffer
  always_ff @(posedge Clock) begin
    if (Reset) begin
      buf_mem_valid_r <= 1'b0;
      buf_mem_addr_r  <= {ADDR_W{1'b0}};
      buf_mem_data_r  <= {DATA_W{1'b0}};
    end else if (mem_accept_s && addr_is_live(mem_addr)) begin
      buf_mem_valid_r <= 1'b1;
      buf_mem_addr_r  <= mem_addr;
      buf_mem_data_r  <= mem_data;
    end else if (grant_mem_s) begin
      buf_mem_valid_r <= 1'b0;
    end else begin
      buf_mem_valid_r <= buf_mem_valid_r;
    end
  end

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
  // Preference pointer: after a contested grant the loser becomes preferred
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rr_ptr_r <= SRC_ALU;
    end else if (contested_s) begin
      rr_ptr_r <= grant_alu_s ? SRC_MEM : SRC_ALU;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end
`endif

  // Registered write port; index/data/source hold their last values when idle
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Write_Enable   <= 1'b0;
      Write_Register <= {ADDR_W{1'b0}};
      Write_Data     <= {DATA_W{1'b0}};
      grant_src      <= SRC_ALU;
    end else if (grant_any_s) begin
      Write_Enable   <= 1'b1;
      Write_Register <= issue_addr_s;
      Write_Data     <= issue_data_s;
      grant_src      <= issue_src_s;
    end else begin
      Write_Enable   <= 1'b0;
    end
  end

`ifndef REGFILE_ARB_ROUND_ROBIN_EN
  // Without the pointer a contested cycle needs no extra state.
  logic unused_contested_s;
  assign unused_contested_s = contested_s;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Directed bench for regfile_write_arbiter. Each test pushes the writes it
// expects, in the order they should appear, onto a scoreboard queue as it
// drives the stimulus. A monitor pops one entry for every cycle with
// Write_Enable high and compares index, data and source.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        src;
  } wr_t;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic        we;
  logic [4:0]  wreg;
  logic [31:0] wdata;
  logic        gsrc;
  logic        busy;

  wr_t sb[$];
  wr_t mon_exp;
  int  n_checks;
  int  n_fail;

  regfile_write_arbiter dut (
    .Clock          (clk),
    .Reset          (rst),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_addr       (alu_addr),
    .alu_data       (alu_data),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .Write_Enable   (we),
    .Write_Register (wreg),
    .Write_Data     (wdata),
    .grant_src      (gsrc),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic wr_t mk(input logic [4:0] a, input logic [31:0] d, input logic s);
    wr_t w;
    w.addr = a;
    w.data = d;
    w.src  = s;
    return w;
  endfunction

  // Scoreboard monitor: every issued write must match the queue head
  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_we", 64'(we), 64'd0);
      end else begin
        mon_exp = sb.pop_front();
        chk("wr_addr", 64'(wreg), 64'(mon_exp.addr));
        chk("wr_data", 64'(wdata), 64'(mon_exp.data));
        chk("wr_src", 64'(gsrc), 64'(mon_exp.src));
      end
      chk("we_reg_zero", 64'(wreg == 5'd0), 64'd0);
    end
  end

  // Present both requesters; each drops valid once its handshake completes
  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    logic a_acc;
    logic m_acc;
    int   n;
    alu_valid = av;
    alu_addr  = aa;
    alu_data  = ad;
    mem_valid = mv;
    mem_addr  = ma;
    mem_data  = md;
    n = 0;
    while ((alu_valid || mem_valid) && n < 20) begin
      @(negedge clk);
      a_acc = alu_valid && alu_ready;
      m_acc = mem_valid && mem_ready;
      @(posedge clk);
      #1;
      if (a_acc) alu_valid = 1'b0;
      if (m_acc) mem_valid = 1'b0;
      n++;
    end
    if (alu_valid || mem_valid) begin
      chk("hs_timeout", 64'({alu_valid, mem_valid}), 64'd0);
      alu_valid = 1'b0;
      mem_valid = 1'b0;
    end
  endtask

  // Wait until every expected write has been issued and the buffers are empty
  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    @(posedge clk);
    #2;
    chk("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    alu_valid = 1'b1;
    alu_addr  = 5'd9;
    alu_data  = 32'h0000_0099;
    mem_valid = 1'b0;
    mem_addr  = 5'd0;
    mem_data  = 32'd0;

    // Reset held two cycles with a live ALU request
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_wreg", 64'(wreg), 64'd0);
    chk("rst_wdata", 64'(wdata), 64'd0);
    chk("rst_gsrc", 64'(gsrc), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst       = 1'b0;
    alu_valid = 1'b0;
    @(negedge clk);
    chk("rst_alu_ready", 64'(alu_ready), 64'd1);
    chk("rst_mem_ready", 64'(mem_ready), 64'd1);
    @(posedge clk);
    #1;

    // ALU only, then a back-to-back request with no bubble
    sb.push_back(mk(5'd3, 32'h0000_00AA, 1'b0));
    drive(1'b1, 5'd3, 32'h0000_00AA, 1'b0, 5'd0, 32'd0);
    sb.push_back(mk(5'd4, 32'h0000_00BB, 1'b0));
    drive(1'b1, 5'd4, 32'h0000_00BB, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("b2b_we_first", 64'(we), 64'd1);
    chk("b2b_reg_first", 64'(wreg), 64'd3);
    @(negedge clk);
    chk("b2b_we_second", 64'(we), 64'd1);
    chk("b2b_reg_second", 64'(wreg), 64'd4);
    drain();

    // Contested grant, different addresses
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    sb.push_back(mk(5'd5, 32'h0000_0011, 1'b0));
    sb.push_back(mk(5'd6, 32'h0000_0022, 1'b1));
`else
    sb.push_back(mk(5'd6, 32'h0000_0022, 1'b1));
    sb.push_back(mk(5'd5, 32'h0000_0011, 1'b0));
`endif
    drive(1'b1, 5'd5, 32'h0000_0011, 1'b1, 5'd6, 32'h0000_0022);
    @(negedge clk);
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    chk("contest_alu_ready", 64'(alu_ready), 64'd1);
    chk("contest_mem_ready", 64'(mem_ready), 64'd0);
`else
    chk("contest_alu_ready", 64'(alu_ready), 64'd0);
    chk("contest_mem_ready", 64'(mem_ready), 64'd1);
`endif
    chk("contest_busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("contest_alu_ready_next", 64'(alu_ready), 64'd1);
    drain();

    // Same address: MEM first, ALU value ends in the register
    sb.push_back(mk(5'd7, 32'h0000_0002, 1'b1));
    sb.push_back(mk(5'd7, 32'h0000_0001, 1'b0));
    drive(1'b1, 5'd7, 32'h0000_0001, 1'b1, 5'd7, 32'h0000_0002);
    @(negedge clk);
    chk("same_alu_ready", 64'(alu_ready), 64'd0);
    drain();

    // Register 0 write is swallowed
    @(negedge clk);
    chk("r0_mem_ready", 64'(mem_ready), 64'd1);
    @(posedge clk);
    #1;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("r0_busy", 64'(busy), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("r0_no_we", 64'(we), 64'd0);
    end

    // A short run of ALU writes with varied data
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] d;
      logic [4:0]  a;
      d = $urandom;
      a = 5'(i + 10);
      sb.push_back(mk(a, d, 1'b0));
      drive(1'b1, a, d, 1'b0, 5'd0, 32'd0);
    end
    drain();

    // Reset pulse with both buffers full drops the pending writes
    @(posedge clk);
    #1;
    drive(1'b1, 5'd20, 32'h0000_0A0A, 1'b1, 5'd21, 32'h0000_0B0B);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy_before", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy_after", 64'(busy), 64'd0);
    chk("midrst_we", 64'(we), 64'd0);
    repeat (4) begin
      @(negedge clk);
      chk("midrst_no_we", 64'(we), 64'd0);
    end
    chk("midrst_sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
